// File: rtl/rv32i_id_stage.sv
// RV32I instruction-decode stage: 32x32 register file with write-through bypass,
// jump/branch resolution back to fetch, wrong-path squash and the ID/EX register.
module rv32i_id_stage #(
  parameter int unsigned SQUASH_CYCLES = 2,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic        wb_enable,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        jump_enable,
  output logic [31:0] jump_addr,
  output logic [31:0] pc_ex,
  output logic [31:0] iw_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic [4:0]  rd_ex,
  output logic [4:0]  rs1_ex,
  output logic [4:0]  rs2_ex,
  output logic        wb_en_ex,
  output logic        illegal_ex
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned CW  = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);

  typedef enum logic [6:0] {
    OPC_LUI     = 7'b0110111,
    OPC_AUIPC   = 7'b0010111,
    OPC_JAL     = 7'b1101111,
    OPC_JALR    = 7'b1100111,
    OPC_BRANCH  = 7'b1100011,
    OPC_LOAD    = 7'b0000011,
    OPC_STORE   = 7'b0100011,
    OPC_OPIMM   = 7'b0010011,
    OPC_OP      = 7'b0110011,
    OPC_MISCMEM = 7'b0001111,
    OPC_SYSTEM  = 7'b1110011
  } opcode_e;

  logic [31:0]   rf_q [32];
  logic [CW-1:0] sq_q, sq_d;
  logic [4:0]    rs1_idx, rs2_idx, rd_idx;
  logic [2:0]    funct3;
  logic [31:0]   rs1_val, rs2_val;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [31:0]   target;
  logic          has_rd, legal, taken, valid;

  assign rs1_idx = iw_in[19:15];
  assign rs2_idx = iw_in[24:20];
  assign rd_idx  = iw_in[11:7];
  assign funct3  = iw_in[14:12];
  assign valid   = (sq_q == '0);

  assign imm_i = {{20{iw_in[31]}}, iw_in[31:20]};
  assign imm_s = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
  assign imm_b = {{19{iw_in[31]}}, iw_in[31], iw_in[7], iw_in[30:25], iw_in[11:8], 1'b0};
  assign imm_u = {iw_in[31:12], 12'h000};
  assign imm_j = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12], iw_in[20], iw_in[30:21], 1'b0};

  // Writeback in the same cycle is visible to the read (write-through bypass).
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1_idx != '0)
      rs1_val = (wb_enable && wb_rd == rs1_idx) ? wb_data : rf_q[rs1_idx];
    if (rs2_idx != '0)
      rs2_val = (wb_enable && wb_rd == rs2_idx) ? wb_data : rf_q[rs2_idx];
  end

  always_comb begin
    imm    = '0;
    has_rd = 1'b0;
    legal  = 1'b1;
    taken  = 1'b0;
    target = '0;
    case (iw_in[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm    = imm_u;
        has_rd = 1'b1;
      end
      OPC_JAL: begin
        imm    = imm_j;
        has_rd = 1'b1;
        taken  = 1'b1;
        target = pc_in + imm_j;
      end
      OPC_JALR: begin
        imm    = imm_i;
        has_rd = 1'b1;
        taken  = 1'b1;
        target = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        imm    = imm_b;
        target = pc_in + imm_b;
        case (funct3)
          3'b000:  taken = (rs1_val == rs2_val);
          3'b001:  taken = (rs1_val != rs2_val);
          3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  taken = (rs1_val <  rs2_val);
          3'b111:  taken = (rs1_val >= rs2_val);
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: begin
        imm    = imm_i;
        has_rd = 1'b1;
      end
      OPC_MISCMEM: imm = imm_i;
      OPC_STORE:   imm = imm_s;
      OPC_OP:      has_rd = 1'b1;
      default:     legal = 1'b0;
    endcase
  end

  // Reset gates the jump combinationally so fetch never redirects while held.
  assign jump_enable = reset & valid & taken;
  assign jump_addr   = jump_enable ? target : pc_in + 32'd4;

  always_comb begin
    sq_d = sq_q;
    if (jump_enable)
      sq_d = CW'(SQUASH_CYCLES);
    else if (sq_q != '0)
      sq_d = sq_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_q <= '0;
      for (int unsigned i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      sq_q <= sq_d;
      if (wb_enable && wb_rd != '0)
        rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_ex       <= RESET_PC;
      iw_ex       <= NOP;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      rd_ex       <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      wb_en_ex    <= 1'b0;
      illegal_ex  <= 1'b0;
    end else if (valid) begin
      pc_ex       <= pc_in;
      iw_ex       <= iw_in;
      rs1_data_ex <= rs1_val;
      rs2_data_ex <= rs2_val;
      imm_ex      <= imm;
      rd_ex       <= has_rd ? rd_idx : '0;
      rs1_ex      <= rs1_idx;
      rs2_ex      <= rs2_idx;
      wb_en_ex    <= has_rd && (rd_idx != '0);
      illegal_ex  <= !legal;
    end else begin
      pc_ex       <= pc_in;
      iw_ex       <= NOP;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      rd_ex       <= '0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      wb_en_ex    <= 1'b0;
      illegal_ex  <= 1'b0;
    end
  end
endmodule

// File: doc/rv32i_id_stage.md
Name: rv32i_id_stage

Overview:
- Instruction-decode stage of the RV32I pipeline; sits directly downstream of the fetch stage.
- Consumes the fetched instruction word and its PC.
- Holds the 32x32 integer register file, with a writeback port and write-to-read bypass.
- Resolves JAL/JALR/branches, driving jump_enable/jump_addr back to fetch, squashes wrong-path instructions, and registers decoded operands into the ID/EX pipeline register.

Parameters:
SQUASH_CYCLES, 2, number of fetched instructions turned into bubbles after a taken jump (fetch has registered PC plus registered memory data, so two are in flight).
RESET_PC, 32'h0000_0000, PC value presented on pc_ex while the stage holds a bubble out of reset.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
iw_in  input  32  instruction word from fetch
pc_in  input  32  PC of iw_in from fetch
wb_enable  input  1  register-file write enable from writeback
wb_rd  input  5  writeback destination register
wb_data  input  32  writeback data
jump_enable  output  1  taken JAL/JALR/branch this cycle, to fetch (combinational)
jump_addr  output  32  jump target, to fetch (combinational)
pc_ex  output  32  registered PC to EX
iw_ex  output  32  registered instruction word to EX (NOP 32'h0000_0013 when bubble)
rs1_data_ex  output  32  registered rs1 operand
rs2_data_ex  output  32  registered rs2 operand
imm_ex  output  32  registered sign-extended immediate (I/S/B/U/J by opcode; 0 for R-type)
rd_ex  output  5  registered destination register (0 when bubble or no rd)
rs1_ex  output  5  registered rs1 index, for downstream forwarding
rs2_ex  output  5  registered rs2 index, for downstream forwarding
wb_en_ex  output  1  registered "instruction writes rd" flag (0 if rd==0 or bubble)
illegal_ex  output  1  registered unsupported-opcode flag

Behaviour:
- Reset (reset==0, async): all registers x1..x31 cleared to 0; squash counter = 0.
  - EX outputs reset to a bubble: iw_ex=32'h13, pc_ex=RESET_PC, rs1/rs2_data_ex=0, imm_ex=0, rd_ex=rs1_ex=rs2_ex=0, wb_en_ex=0, illegal_ex=0.
  - jump_enable=0 while in reset.
- Register file:
  - x0 always reads 0; writes to x0 ignored.
  - Write occurs on posedge when wb_enable=1.
- Read bypass: if wb_enable && wb_rd==rsN && rsN!=0, operand = wb_data (same-cycle write visible to read).
- Valid: current instruction is valid when the squash counter == 0.
- Jump resolution, combinational, gated by valid:
  - JAL: jump_addr = pc_in + imm_J.
  - JALR: jump_addr = (rs1 + imm_I) & ~1.
  - Branches (funct3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU): compare the bypassed rs1/rs2; if taken, jump_addr = pc_in + imm_B.
  - Signed vs unsigned compare per funct3.
  - All additions modulo 2^32.
  - Not taken or invalid: jump_enable=0, jump_addr = pc_in + 4.
  - jump_enable=0 for any branch with illegal funct3 (010/011); illegal_ex set.
- Squash counter:
  - On a posedge where jump_enable=1, load SQUASH_CYCLES.
  - Else, if nonzero, decrement by 1.
  - Counter saturates at 0.
  - A jump cannot be taken while the counter is nonzero (invalid instructions never jump).
- ID/EX register, updated every posedge (no stall input):
  - Valid: capture decoded fields; rs*_data_ex = bypassed operands.
  - Invalid: load a bubble (same values as reset), except pc_ex = pc_in.
- Link value: JAL/JALR have wb_en_ex=1; EX computes pc_ex+4 (this stage does not).
- Illegal detection:
  - Opcodes outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM} set illegal_ex=1 and wb_en_ex=0.
  - illegal_ex=1 never causes a jump.
- Reset mid-operation: an asserted reset cancels any pending squash and combinationally forces jump_enable=0 immediately.

Test Plan:
- Reset: hold reset=0 with iw_in=JAL -> jump_enable=0, iw_ex=32'h13, all regs read 0 after release.
- Writeback + bypass: wb x5=32'hDEAD_BEEF while iw_in=ADD x1,x5,x0 -> rs1_data_ex=32'hDEAD_BEEF next edge; write to x0 -> x0 still reads 0.
- Branches: x1=32'hFFFF_FFFF, x2=1, pc_in=32'h100, offset -8.
  - BLT x1,x2 -> jump_enable=1, jump_addr=32'h0F8.
  - BLTU x1,x2 -> jump_enable=0, jump_addr=32'h104.
- JALR alignment: x3=32'h1001, JALR x1,5(x3) -> jump_addr=32'h1006; pc_in=32'hFFFF_FFFC with JAL +8 -> jump_addr=32'h4 (wrap).
- Squash:
  - Taken JAL at cycle n -> iw_ex at n+1 is the JAL, then two bubbles (iw_ex=32'h13, wb_en_ex=0) at n+2/n+3 even if a branch arrives.
  - Branch arriving at n+3 (counter now 0) is honoured.
- Illegal: iw_in=32'hFFFF_FFFF -> illegal_ex=1, wb_en_ex=0, jump_enable=0; async reset asserted mid-squash -> bubble outputs immediately, counter 0.
